// File: rtl/imem_boot_ctrl.sv
// Boot loader and address-port arbiter for the instruction memory: assembles a
// little-endian byte stream into words, writes them, then hands the port to fetch.
module imem_boot_ctrl #(
  parameter int DWIDTH        = 32,
  parameter int MEM_SIZE      = 16384,
  parameter int BOOT_ON_RESET = 1,
  localparam int ADDR_SIZE    = $clog2(MEM_SIZE)
) (
  input  logic                 Clk_Core,
  input  logic                 Rst_Core,
  input  logic                 Boot_Start,
  input  logic [7:0]           Rx_Data,
  input  logic                 Rx_Valid,
  output logic                 Rx_Ready,
  input  logic [DWIDTH-1:0]    Fetch_PC,
  output logic [ADDR_SIZE-1:0] Mem_Addr,
  output logic                 Mem_We,
  output logic [31:0]          Mem_Wdata,
  output logic                 Core_Stall,
  output logic                 Boot_Done,
  output logic                 Boot_Err
);

  typedef enum logic [1:0] {S_LEN, S_LOAD, S_RUN, S_ERR} state_t;

  localparam state_t      RST_STATE  = (BOOT_ON_RESET != 0) ? S_LEN : S_RUN;
  localparam logic        RST_STALL  = (BOOT_ON_RESET != 0);
  localparam logic [31:0] MEM_SIZE_W = 32'(MEM_SIZE);

  state_t               state, state_nxt;
  logic [1:0]           byte_cnt, byte_cnt_nxt;
  logic [ADDR_SIZE:0]   word_cnt, word_cnt_nxt;
  logic [31:0]          len, len_nxt;
  logic [31:0]          asm_word, asm_word_nxt;
  logic                 we_q, we_nxt;
  logic [31:0]          wdata_q, wdata_nxt;
  logic                 done_q, done_nxt;
  logic                 err_q, err_nxt;
  logic                 stall_q, stall_nxt;

  logic [32:0]          wc_ext;
  logic [32:0]          words_rcvd;
  logic                 rx_ready;
  logic                 rx_fire;
  logic [31:0]          word_full;
  logic                 unused_pc_bits;

  // A word counts as received as soon as its write is pending, so the last
  // word's write cycle already deasserts Rx_Ready.
  assign wc_ext     = {{(32-ADDR_SIZE){1'b0}}, word_cnt};
  assign words_rcvd = wc_ext + {32'd0, we_q};
  assign rx_ready   = (state == S_LEN) ||
                      ((state == S_LOAD) && (words_rcvd < {1'b0, len}));
  assign rx_fire    = Rx_Valid && rx_ready;
  assign word_full  = {Rx_Data, asm_word[31:8]};

  assign Rx_Ready   = rx_ready;
  assign Mem_Addr   = (state == S_RUN) ? Fetch_PC[ADDR_SIZE+1:2] : word_cnt[ADDR_SIZE-1:0];
  assign Mem_We     = we_q;
  assign Mem_Wdata  = wdata_q;
  assign Core_Stall = stall_q;
  assign Boot_Done  = done_q;
  assign Boot_Err   = err_q;

  assign unused_pc_bits = ^{Fetch_PC[DWIDTH-1:ADDR_SIZE+2], Fetch_PC[1:0]};

  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      state    <= RST_STATE;
      byte_cnt <= '0;
      word_cnt <= '0;
      len      <= '0;
      asm_word <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      stall_q  <= RST_STALL;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      word_cnt <= word_cnt_nxt;
      len      <= len_nxt;
      asm_word <= asm_word_nxt;
      we_q     <= we_nxt;
      wdata_q  <= wdata_nxt;
      done_q   <= done_nxt;
      err_q    <= err_nxt;
      stall_q  <= stall_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    word_cnt_nxt = word_cnt;
    len_nxt      = len;
    asm_word_nxt = asm_word;
    we_nxt       = 1'b0;
    wdata_nxt    = wdata_q;
    done_nxt     = done_q;
    err_nxt      = err_q;
    stall_nxt    = stall_q;

    case (state)
      S_LEN: begin
        if (rx_fire) begin
          asm_word_nxt = word_full;
          byte_cnt_nxt = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            len_nxt = word_full;
            if (word_full == 32'd0) begin
              state_nxt = S_RUN;
              done_nxt  = 1'b1;
              stall_nxt = 1'b0;
            end else if (word_full > MEM_SIZE_W) begin
              state_nxt = S_ERR;
              err_nxt   = 1'b1;
            end else begin
              state_nxt    = S_LOAD;
              word_cnt_nxt = '0;
            end
          end
        end
      end

      S_LOAD: begin
        if (we_q) begin
          word_cnt_nxt = word_cnt + {{ADDR_SIZE{1'b0}}, 1'b1};
          if (wc_ext + 33'd1 == {1'b0, len}) begin
            state_nxt = S_RUN;
            done_nxt  = 1'b1;
            stall_nxt = 1'b0;
          end
        end
        if (rx_fire) begin
          asm_word_nxt = word_full;
          byte_cnt_nxt = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            we_nxt    = 1'b1;
            wdata_nxt = word_full;
          end
        end
      end

      default: begin
        // RUN and ERR: only a reload request moves us.
        if (Boot_Start) begin
          state_nxt    = S_LEN;
          byte_cnt_nxt = '0;
          word_cnt_nxt = '0;
          len_nxt      = '0;
          asm_word_nxt = '0;
          done_nxt     = 1'b0;
          err_nxt      = 1'b0;
          stall_nxt    = 1'b1;
        end
      end
    endcase
  end

endmodule
